// File: rtl/ampl_sweep_pkg.sv
// Shared types and constants for the amplitude sweep sequencer.
package ampl_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_KICK      = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_WRITE     = 3'd6,
        ST_FINISH    = 3'd7
    } sweep_state_e;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_MAG_MASK = 32'h7FFF_FFFF;

    // Magnitudes are non-negative floats, so an unsigned compare of the
    // exponent/mantissa field orders them; the sign bit is disregarded.
    function automatic logic mag_gt(input logic [31:0] a, input logic [31:0] b);
        return (a & FP_MAG_MASK) > (b & FP_MAG_MASK);
    endfunction

endpackage

// File: rtl/ampl_peak_track.sv
// Running peak of the magnitudes written during a sweep; ties keep the lower bin.
module ampl_peak_track
    import ampl_sweep_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              clear,
    input  logic              update,
    input  logic [ADDR_W-1:0] bin,
    input  logic [31:0]       val,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [31:0]       peak_val
);

    // peak register: cleared on sweep start, replaced only on a strictly larger magnitude
    always_ff @(posedge clk) begin
        if (n_reset) begin
            peak_bin <= {ADDR_W{1'b0}};
            peak_val <= FP_ZERO;
        end else if (clear) begin
            peak_bin <= {ADDR_W{1'b0}};
            peak_val <= FP_ZERO;
        end else if (update && mag_gt(val, peak_val)) begin
            peak_bin <= bin;
            peak_val <= val;
        end
    end

endmodule

// File: rtl/ampl_sweep_ctrl.sv
// Sweeps a spectrum through the shared amplitude engine one bin at a time,
// writing each magnitude out and tracking the peak bin.
module ampl_sweep_ctrl
    import ampl_sweep_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [ADDR_W:0]   n_bins,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [31:0]       peak_val,
    output logic              spec_rd_en,
    output logic [ADDR_W-1:0] spec_rd_addr,
    input  logic [DATA_W-1:0] spec_re,
    input  logic [DATA_W-1:0] spec_im,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_x,
    output logic [DATA_W-1:0] eng_y,
    input  logic [DATA_W-1:0] eng_ampl,
    input  logic              eng_done,
    output logic              mag_wr_en,
    output logic [ADDR_W-1:0] mag_wr_addr,
    output logic [DATA_W-1:0] mag_wr_data
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BIN_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] BIN_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   NB_ZERO  = {(ADDR_W+1){1'b0}};

    sweep_state_e      state_r, state_s;
    logic [ADDR_W-1:0] bin_r, bin_s;
    logic [ADDR_W-1:0] last_r, last_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              start_ok_s;
    logic              waiting_s;
    logic              tmo_s;
    logic              tmo_hit_s;

    assign start_ok_s = (state_r == ST_IDLE) && start;
    assign waiting_s  = (state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE);
    assign tmo_s      = (cnt_r == TMO_LAST);
    assign tmo_hit_s  = waiting_s && (state_s == ST_FINISH);
    // Requests above the RAM depth clamp to a full sweep.
    assign last_s     = n_bins[ADDR_W] ? {ADDR_W{1'b1}} : (n_bins[ADDR_W-1:0] - BIN_ONE);

    // next-state logic; abort overrides every transition out of a busy state
    always_comb begin
        state_s = state_r;
        if (abort && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = (n_bins == NB_ZERO) ? ST_FINISH : ST_READ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_READ:  state_s = ST_LOAD;
                ST_LOAD:  state_s = ST_KICK;
                ST_KICK:  state_s = ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (!eng_done) begin
                        state_s = ST_WAIT_DONE;
                    end else if (tmo_s) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (eng_done) begin
                        state_s = ST_WRITE;
                    end else if (tmo_s) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_WAIT_DONE;
                    end
                end
                ST_WRITE: begin
                    if (bin_r == last_r) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_READ;
                    end
                end
                ST_FINISH: state_s = ST_IDLE;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // bin index for the next cycle
    always_comb begin
        bin_s = bin_r;
        if (start_ok_s) begin
            bin_s = BIN_ZERO;
        end else if ((state_r == ST_WRITE) && (state_s == ST_READ)) begin
            bin_s = bin_r + BIN_ONE;
        end else begin
            bin_s = bin_r;
        end
    end

    // control state and strobes, registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (n_reset) begin
            state_r    <= ST_IDLE;
            bin_r      <= BIN_ZERO;
            last_r     <= BIN_ZERO;
            cnt_r      <= CNT_ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            spec_rd_en <= 1'b0;
            eng_start  <= 1'b0;
            mag_wr_en  <= 1'b0;
        end else begin
            state_r    <= state_s;
            bin_r      <= bin_s;
            busy       <= (state_s != ST_IDLE);
            done       <= (state_s == ST_FINISH);
            spec_rd_en <= (state_s == ST_READ);
            eng_start  <= (state_s == ST_KICK);
            mag_wr_en  <= (state_s == ST_WRITE);
            if (start_ok_s) begin
                last_r <= last_s;
            end
            // One budget spans both engine waits of a bin.
            if (state_r == ST_KICK) begin
                cnt_r <= CNT_ZERO;
            end else if (waiting_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (start_ok_s) begin
                error <= 1'b0;
            end else if (tmo_hit_s) begin
                error <= 1'b1;
            end
        end
    end

    // datapath registers: RAM address, engine operands, magnitude write word
    always_ff @(posedge clk) begin
        if (n_reset) begin
            spec_rd_addr <= BIN_ZERO;
            eng_x        <= FP_ZERO;
            eng_y        <= FP_ZERO;
            mag_wr_addr  <= BIN_ZERO;
            mag_wr_data  <= FP_ZERO;
        end else begin
            if (state_s == ST_READ) begin
                spec_rd_addr <= bin_s;
            end
            // Operands stay put until the next bin's load; the engine samples them late.
            if ((state_r == ST_LOAD) && (state_s == ST_KICK)) begin
                eng_x <= spec_re;
                eng_y <= spec_im;
            end
            if (state_s == ST_WRITE) begin
                mag_wr_addr <= bin_r;
                mag_wr_data <= eng_ampl;
            end
        end
    end

    ampl_peak_track #(
        .ADDR_W (ADDR_W)
    ) u_peak (
        .clk      (clk),
        .n_reset  (n_reset),
        .clear    (start_ok_s),
        .update   (state_s == ST_WRITE),
        .bin      (bin_r),
        .val      (eng_ampl),
        .peak_bin (peak_bin),
        .peak_val (peak_val)
    );

endmodule

// File: tb/tb_ampl_sweep_ctrl.sv
// Self-checking bench for ampl_sweep_ctrl: spectrum RAM and engine models,
// a magnitude/peak reference model, and a per-cycle write checker.
module tb_ampl_sweep_ctrl;

    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_reset, start, abort, eng_done;
    logic [AW:0]   n_bins;
    logic          busy, done, error, spec_rd_en, eng_start, mag_wr_en;
    logic [AW-1:0] peak_bin, spec_rd_addr, mag_wr_addr;
    logic [31:0]   peak_val, spec_re, spec_im, eng_x, eng_y, eng_ampl, mag_wr_data;

    logic          t_start, t_abort, t_eng_done;
    logic [AW:0]   t_n_bins;
    logic          t_busy, t_done, t_error, t_spec_rd_en, t_eng_start, t_mag_wr_en;
    logic [AW-1:0] t_peak_bin, t_spec_rd_addr, t_mag_wr_addr;
    logic [31:0]   t_peak_val, t_spec, t_eng_x, t_eng_y, t_eng_ampl, t_mag_wr_data;

    ampl_sweep_ctrl #(.ADDR_W(AW), .DATA_W(32), .TIMEOUT(1023)) u_dut (
        .clk(clk), .n_reset(n_reset), .start(start), .n_bins(n_bins), .abort(abort),
        .busy(busy), .done(done), .error(error), .peak_bin(peak_bin), .peak_val(peak_val),
        .spec_rd_en(spec_rd_en), .spec_rd_addr(spec_rd_addr), .spec_re(spec_re), .spec_im(spec_im),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_ampl(eng_ampl), .eng_done(eng_done),
        .mag_wr_en(mag_wr_en), .mag_wr_addr(mag_wr_addr), .mag_wr_data(mag_wr_data)
    );

    // Second instance with a short timeout and an engine that never responds.
    ampl_sweep_ctrl #(.ADDR_W(AW), .DATA_W(32), .TIMEOUT(15)) u_dut_tmo (
        .clk(clk), .n_reset(n_reset), .start(t_start), .n_bins(t_n_bins), .abort(t_abort),
        .busy(t_busy), .done(t_done), .error(t_error), .peak_bin(t_peak_bin), .peak_val(t_peak_val),
        .spec_rd_en(t_spec_rd_en), .spec_rd_addr(t_spec_rd_addr), .spec_re(t_spec), .spec_im(t_spec),
        .eng_start(t_eng_start), .eng_x(t_eng_x), .eng_y(t_eng_y), .eng_ampl(t_eng_ampl),
        .eng_done(t_eng_done), .mag_wr_en(t_mag_wr_en), .mag_wr_addr(t_mag_wr_addr),
        .mag_wr_data(t_mag_wr_data)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          wr_cnt, done_cnt, rd_cnt, kick_cnt, t_wr_cnt, t_kick_cyc, t_done_cyc;
    logic [31:0] re_tab [8];
    logic [31:0] im_tab [8];
    logic [31:0] wr_log [8];
    wr_t         exp_q [$];
    logic [31:0] exp_pv;
    int          exp_pb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] mag_model(input int i);
        real a, b;
        a = f2r(re_tab[i]);
        b = f2r(im_tab[i]);
        return r2f($sqrt(a * a + b * b));
    endfunction

    // expected writes and peak for a complete sweep of n bins
    task automatic expect_sweep(input int n);
        wr_t w;
        exp_pv = 32'h0;
        exp_pb = 0;
        for (int i = 0; i < n; i++) begin
            w.a = AW'(i);
            w.d = mag_model(i);
            exp_q.push_back(w);
            if (w.d[30:0] > exp_pv[30:0]) begin
                exp_pv = w.d;
                exp_pb = i;
            end
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0; done_cnt = 0; rd_cnt = 0; kick_cnt = 0;
        for (int i = 0; i < 8; i++) wr_log[i] = 32'hFFFF_FFFF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [AW:0] n);
        tick();
        start  = 1'b1;
        n_bins = n;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // spectrum RAM: data appears the cycle after the read strobe
    initial begin
        bit            pend;
        logic [AW-1:0] a;
        pend = 1'b0; a = '0; spec_re = 32'h0; spec_im = 32'h0;
        forever begin
            @(negedge clk);
            if (pend) begin
                spec_re = re_tab[a];
                spec_im = im_tab[a];
            end
            pend = spec_rd_en;
            a    = spec_rd_addr;
        end
    end

    // engine: busy two cycles after the kick, result and idle twenty cycles later
    initial begin
        int          t;
        bit          run;
        logic [31:0] res;
        real         x, y;
        t = 0; run = 1'b0; res = 32'h0; eng_done = 1'b1; eng_ampl = 32'h0;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                x   = f2r(eng_x);
                y   = f2r(eng_y);
                res = r2f($sqrt(x * x + y * y));
                run = 1'b1;
                t   = 0;
            end else if (run) begin
                t++;
                if (t == 2) eng_done = 1'b0;
                if (t == 22) begin
                    eng_done = 1'b1;
                    eng_ampl = res;
                    run      = 1'b0;
                end
            end
        end
    end

    // per-cycle checker: every magnitude write must match the model's next entry
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (mag_wr_en) begin
                wr_cnt++;
                wr_log[mag_wr_addr] = mag_wr_data;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mag_write: got write addr %0d data %h, expected no write",
                             mag_wr_addr, mag_wr_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("mag_wr_addr", {29'd0, mag_wr_addr}, {29'd0, w.a});
                    chk("mag_wr_data", mag_wr_data, w.d);
                end
            end
            if (done)        done_cnt++;
            if (spec_rd_en)  rd_cnt++;
            if (eng_start)   kick_cnt++;
            if (t_eng_start) t_kick_cyc = cyc;
            if (t_done)      t_done_cyc = cyc;
            if (t_mag_wr_en) t_wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        n_reset = 1'b1; start = 1'b0; abort = 1'b0; n_bins = '0;
        t_start = 1'b0; t_abort = 1'b0; t_n_bins = '0; t_eng_done = 1'b1;
        t_eng_ampl = 32'h0; t_spec = 32'h3F80_0000;
        t_wr_cnt = 0; t_kick_cyc = 0; t_done_cyc = 0;
        re_tab = '{32'h4040_0000, 32'h0, 32'h40C0_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h4100_0000, 32'hBF80_0000, 32'h0};
        im_tab = '{32'h4080_0000, 32'h0, 32'h4100_0000, 32'h4040_0000,
                   32'h4140_0000, 32'h40C0_0000, 32'h0, 32'h4000_0000};
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", {31'd0, |{busy, done, error, spec_rd_en, eng_start, mag_wr_en,
            peak_bin, peak_val, spec_rd_addr, eng_x, eng_y, mag_wr_addr, mag_wr_data}}, 32'd0);
        tick();
        n_reset = 1'b0;

        // three bins with an ignored mid-sweep start and n_bins change
        clear_stats();
        expect_sweep(3);
        chk("model_pin_bin0", exp_q[0].d, 32'h40A0_0000);
        chk("model_pin_bin2", exp_q[2].d, 32'h4120_0000);
        start_sweep(4'd3);
        repeat (5) tick();
        start = 1'b1; n_bins = 4'd1;
        tick();
        start = 1'b0;
        wait_done("A_done_seen", 400);
        chk("A_peak_bin", {29'd0, peak_bin}, 32'(exp_pb));
        chk("A_peak_val", peak_val, exp_pv);
        chk("A_peak_val_lit", peak_val, 32'h4120_0000);
        chk("A_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        chk("A_busy_after", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("A_wr_bin0", wr_log[0], 32'h40A0_0000);
        chk("A_wr_bin1", wr_log[1], 32'h0000_0000);
        chk("A_wr_bin2", wr_log[2], 32'h4120_0000);
        chk("A_done_count", 32'(done_cnt), 32'd1);
        chk("A_reads", 32'(rd_cnt), 32'd3);
        chk("A_exp_left", 32'(exp_q.size()), 32'd0);

        // zero-length sweep: busy for exactly the done cycle, no strobes
        clear_stats();
        start_sweep(4'd0);
        @(negedge clk);
        chk("Z_done", {31'd0, done}, 32'd1);
        chk("Z_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("Z_done_off", {31'd0, done}, 32'd0);
        chk("Z_busy_off", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("Z_strobes", 32'(rd_cnt + kick_cnt + wr_cnt), 32'd0);
        chk("Z_done_count", 32'(done_cnt), 32'd1);

        // equal magnitudes: the lower bin keeps the peak
        clear_stats();
        re_tab[1] = 32'h4080_0000; im_tab[1] = 32'h4040_0000;
        expect_sweep(2);
        chk("T_model_pin_pb", 32'(exp_pb), 32'd0);
        start_sweep(4'd2);
        wait_done("T_done_seen", 300);
        chk("T_peak_bin", {29'd0, peak_bin}, 32'd0);
        chk("T_peak_val", peak_val, 32'h40A0_0000);
        @(negedge clk);
        chk("T_wr_bin1", wr_log[1], 32'h40A0_0000);
        re_tab[1] = 32'h0; im_tab[1] = 32'h0;

        // oversized request saturates to the RAM depth
        clear_stats();
        expect_sweep(8);
        start_sweep(4'd15);
        wait_done("S_done_seen", 600);
        chk("S_peak_bin", {29'd0, peak_bin}, 32'(exp_pb));
        chk("S_peak_val_lit", peak_val, 32'h4150_0000);
        @(negedge clk);
        chk("S_writes", 32'(wr_cnt), 32'd8);
        chk("S_exp_left", 32'(exp_q.size()), 32'd0);

        // abort while bin 1 is in the engine
        clear_stats();
        expect_sweep(1);
        start_sweep(4'd4);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (kick_cnt == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("B_second_kick_seen", {31'd0, seen}, 32'd1);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("B_busy_after_abort", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("B_writes", 32'(wr_cnt), 32'd1);
        chk("B_no_done", 32'(done_cnt), 32'd0);
        chk("B_peak_val", peak_val, 32'h40A0_0000);
        chk("B_error", {31'd0, error}, 32'd0);
        chk("B_exp_left", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a sweep
        clear_stats();
        start_sweep(4'd3);
        repeat (6) tick();
        n_reset = 1'b1;
        tick();
        @(negedge clk);
        chk("R_outputs_zero", {31'd0, |{busy, done, error, spec_rd_en, eng_start, mag_wr_en,
            peak_bin, peak_val, spec_rd_addr, eng_x, eng_y, mag_wr_addr, mag_wr_data}}, 32'd0);
        tick();
        n_reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("R_no_writes", 32'(wr_cnt), 32'd0);
        chk("R_idle", {31'd0, busy}, 32'd0);

        // stuck engine on the short-timeout instance
        t_done_cyc = -1;
        tick();
        t_start = 1'b1; t_n_bins = 4'd1;
        tick();
        t_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("O_done_seen", {31'd0, seen}, 32'd1);
        chk("O_kick_to_done", 32'(t_done_cyc - t_kick_cyc), 32'd16);
        chk("O_error_set", {31'd0, t_error}, 32'd1);
        chk("O_no_write", 32'(t_wr_cnt), 32'd0);
        tick();
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        @(negedge clk);
        chk("O_error_cleared", {31'd0, t_error}, 32'd0);
        chk("O_busy_again", {31'd0, t_busy}, 32'd1);
        repeat (5) tick();
        t_abort = 1'b1;
        tick();
        t_abort = 1'b0;
        @(negedge clk);
        chk("O_abort_busy", {31'd0, t_busy}, 32'd0);
        chk("O_abort_error", {31'd0, t_error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
